// File: rtl/el_pipeline_cpu.sv
// el_pipeline_cpu: five-stage 16-bit pipelined CPU with an internal program ROM and an external async SRAM.
// Optional build macro EL_SRAM_CLEAR_EN zeroes SRAM words 0..63 after reset before fetch begins.
module el_pipeline_cpu #(
    parameter int IMEM_DEPTH = 64,
    parameter int RESET_PC   = 0
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        forward_enable,
    inout  wire  [15:0] sram_DQ_mem,
    output logic [17:0] sram_ADDR_mem,
    output logic        sram_UB_N_mem,
    output logic        sram_LB_N_mem,
    output logic        sram_WE_N_mem,
    output logic        sram_CE_N_mem,
    output logic        sram_OE_N_mem
);
    localparam int PCW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd15;
    localparam logic [15:0] NOP_WORD = {OP_NOP, 12'h000};

    function automatic logic [15:0] rom_word(input logic [PCW-1:0] addr);
        logic [15:0] w;
        case (32'(addr))
            32'd0:   w = 16'h5205;
            32'd1:   w = 16'h5443;
            32'd2:   w = 16'h1650;
            32'd3:   w = 16'h7602;
            32'd4:   w = 16'h6802;
            32'd5:   w = 16'h1B20;
            32'd6:   w = 16'h7A03;
            32'd7:   w = 16'h8001;
            32'd8:   w = 16'h7209;
            32'd9:   w = 16'h2D58;
            32'd10:  w = 16'h7C04;
            32'd11:  w = 16'hF000;
            default: w = NOP_WORD;
        endcase
        return w;
    endfunction

    function automatic logic [PCW-1:0] pc_wrap(input int value);
        int m;
        m = value % IMEM_DEPTH;
        m = (m < 0) ? m + IMEM_DEPTH : m;
        return PCW'(m);
    endfunction

    logic [PCW-1:0] pc_r, ifid_pc_r, idex_pc_r;
    logic [15:0]    ifid_instr_r;
    logic           halted_r;
    logic [3:0]     idex_op_r;
    logic [2:0]     idex_dest_r, idex_s1_r, idex_s2_r;
    logic [15:0]    idex_v1_r, idex_v2_r;
    logic [5:0]     idex_imm_r;
    logic           idex_fwd_r;
    logic [2:0]     exmem_dest_r, memwb_dest_r;
    logic [15:0]    exmem_result_r, memwb_val_r;
    logic           exmem_load_r;
    logic [15:0]    rf_r [0:7];
    logic           we_n_r, oe_n_r, ce_n_r;
    logic [17:0]    addr_r;
    logic [15:0]    wdata_r;

    logic [3:0]     id_op_s;
    logic [2:0]     id_s1_s, id_s2_s, id_dest_s;
    logic [15:0]    id_v1_s, id_v2_s;
    logic           id_stall_s, match_ex_s, match_mem_s, halt_id_s, fetch_hold_s;
    logic [15:0]    ex_a_s, ex_b_s, ex_imm_s, ex_result_s;
    logic           ex_load_s, ex_store_s, br_taken_s;
    logic [PCW-1:0] br_target_s;

`ifdef EL_SRAM_CLEAR_EN
    logic           clr_active_r;
    logic [5:0]     clr_cnt_r;
    assign fetch_hold_s = clr_active_r;
`else
    assign fetch_hold_s = 1'b0;
`endif

    // Decode, register read with same-cycle WB bypass, and RAW interlock decision.
    always_comb begin
        id_op_s   = ifid_instr_r[15:12];
        id_s1_s   = 3'd0;
        id_s2_s   = 3'd0;
        id_dest_s = 3'd0;
        case (id_op_s)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                id_s1_s   = ifid_instr_r[8:6];
                id_s2_s   = ifid_instr_r[5:3];
                id_dest_s = ifid_instr_r[11:9];
            end
            OP_ADDI, OP_LW: begin
                id_s1_s   = ifid_instr_r[8:6];
                id_dest_s = ifid_instr_r[11:9];
            end
            OP_SW: begin
                id_s1_s = ifid_instr_r[8:6];
                id_s2_s = ifid_instr_r[11:9];
            end
            OP_BEQ: begin
                id_s1_s = ifid_instr_r[11:9];
                id_s2_s = ifid_instr_r[8:6];
            end
            default: id_dest_s = 3'd0;
        endcase
        if (id_s1_s == 3'd0) id_v1_s = 16'h0000;
        else if (memwb_dest_r == id_s1_s) id_v1_s = memwb_val_r;
        else id_v1_s = rf_r[id_s1_s];
        if (id_s2_s == 3'd0) id_v2_s = 16'h0000;
        else if (memwb_dest_r == id_s2_s) id_v2_s = memwb_val_r;
        else id_v2_s = rf_r[id_s2_s];
        // Unused sources are 0 and dest 0 means "no write", so equality alone flags a real hazard.
        match_ex_s  = (idex_dest_r != 3'd0) && ((id_s1_s == idex_dest_r) || (id_s2_s == idex_dest_r));
        match_mem_s = (exmem_dest_r != 3'd0) && ((id_s1_s == exmem_dest_r) || (id_s2_s == exmem_dest_r));
        if (forward_enable) id_stall_s = match_ex_s && (idex_op_r == OP_LW);
        else id_stall_s = match_ex_s || match_mem_s;
    end

    // Execute: operand forwarding (only if chosen when the instruction left ID), ALU and branch resolve.
    always_comb begin
        if (idex_fwd_r && (idex_s1_r != 3'd0) && (exmem_dest_r == idex_s1_r)) ex_a_s = exmem_result_r;
        else if (idex_fwd_r && (idex_s1_r != 3'd0) && (memwb_dest_r == idex_s1_r)) ex_a_s = memwb_val_r;
        else ex_a_s = idex_v1_r;
        if (idex_fwd_r && (idex_s2_r != 3'd0) && (exmem_dest_r == idex_s2_r)) ex_b_s = exmem_result_r;
        else if (idex_fwd_r && (idex_s2_r != 3'd0) && (memwb_dest_r == idex_s2_r)) ex_b_s = memwb_val_r;
        else ex_b_s = idex_v2_r;
        ex_imm_s = {{10{idex_imm_r[5]}}, idex_imm_r};
        case (idex_op_r)
            OP_ADD:               ex_result_s = ex_a_s + ex_b_s;
            OP_SUB:               ex_result_s = ex_a_s - ex_b_s;
            OP_AND:               ex_result_s = ex_a_s & ex_b_s;
            OP_OR:                ex_result_s = ex_a_s | ex_b_s;
            OP_ADDI, OP_LW, OP_SW: ex_result_s = ex_a_s + ex_imm_s;
            default:              ex_result_s = 16'h0000;
        endcase
        ex_load_s   = (idex_op_r == OP_LW);
        ex_store_s  = (idex_op_r == OP_SW);
        br_taken_s  = (idex_op_r == OP_BEQ) && (ex_a_s == ex_b_s);
        br_target_s = pc_wrap(int'(idex_pc_r) + 1 + int'($signed(idex_imm_r)));
        halt_id_s   = (id_op_s == OP_HALT) && !br_taken_s;
    end

    // Pipeline registers: fetch/PC control, ID/EX, EX/MEM and MEM/WB.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pc_r           <= PCW'(RESET_PC);
            ifid_instr_r   <= NOP_WORD;
            ifid_pc_r      <= {PCW{1'b0}};
            halted_r       <= 1'b0;
            idex_op_r      <= OP_NOP;
            idex_dest_r    <= 3'd0;
            idex_s1_r      <= 3'd0;
            idex_s2_r      <= 3'd0;
            idex_v1_r      <= 16'h0000;
            idex_v2_r      <= 16'h0000;
            idex_imm_r     <= 6'd0;
            idex_pc_r      <= {PCW{1'b0}};
            idex_fwd_r     <= 1'b0;
            exmem_dest_r   <= 3'd0;
            exmem_result_r <= 16'h0000;
            exmem_load_r   <= 1'b0;
            memwb_dest_r   <= 3'd0;
            memwb_val_r    <= 16'h0000;
        end else begin
            if (br_taken_s) begin
                pc_r         <= br_target_s;
                ifid_instr_r <= NOP_WORD;
            end else if (fetch_hold_s || halted_r || halt_id_s) begin
                ifid_instr_r <= NOP_WORD;
            end else if (!id_stall_s) begin
                ifid_instr_r <= rom_word(pc_r);
                ifid_pc_r    <= pc_r;
                pc_r         <= pc_wrap(int'(pc_r) + 1);
            end
            halted_r <= halted_r | halt_id_s;
            if (br_taken_s || id_stall_s) begin
                idex_op_r   <= OP_NOP;
                idex_dest_r <= 3'd0;
                idex_s1_r   <= 3'd0;
                idex_s2_r   <= 3'd0;
            end else begin
                idex_op_r   <= id_op_s;
                idex_dest_r <= id_dest_s;
                idex_s1_r   <= id_s1_s;
                idex_s2_r   <= id_s2_s;
                idex_v1_r   <= id_v1_s;
                idex_v2_r   <= id_v2_s;
                idex_imm_r  <= ifid_instr_r[5:0];
                idex_pc_r   <= ifid_pc_r;
                idex_fwd_r  <= forward_enable;
            end
            exmem_dest_r   <= idex_dest_r;
            exmem_result_r <= ex_result_s;
            exmem_load_r   <= ex_load_s;
            memwb_dest_r   <= exmem_dest_r;
            memwb_val_r    <= exmem_load_r ? sram_DQ_mem : exmem_result_r;
        end
    end

    // Register file; r0 is never written.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf_r[i] <= 16'h0000;
        end else if (memwb_dest_r != 3'd0) begin
            rf_r[memwb_dest_r] <= memwb_val_r;
        end
    end

    // SRAM bus controls, loaded alongside EX/MEM so they reflect the instruction now in MEM.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            we_n_r  <= 1'b1;
            oe_n_r  <= 1'b1;
            ce_n_r  <= 1'b1;
            addr_r  <= 18'd0;
            wdata_r <= 16'h0000;
`ifdef EL_SRAM_CLEAR_EN
            clr_active_r <= 1'b1;
            clr_cnt_r    <= 6'd0;
`endif
        end else begin
            ce_n_r <= 1'b0;
`ifdef EL_SRAM_CLEAR_EN
            if (clr_active_r) begin
                we_n_r       <= 1'b0;
                oe_n_r       <= 1'b1;
                addr_r       <= {12'd0, clr_cnt_r};
                wdata_r      <= 16'h0000;
                clr_cnt_r    <= clr_cnt_r + 6'd1;
                clr_active_r <= (clr_cnt_r != 6'd63);
            end else
`endif
            begin
                we_n_r  <= !ex_store_s;
                oe_n_r  <= !ex_load_s;
                wdata_r <= ex_b_s;
                if (ex_store_s || ex_load_s) addr_r <= {2'b00, ex_result_s};
            end
        end
    end

    assign sram_DQ_mem   = we_n_r ? {16{1'bz}} : wdata_r;
    assign sram_ADDR_mem = addr_r;
    assign sram_UB_N_mem = 1'b0;
    assign sram_LB_N_mem = 1'b0;
    assign sram_WE_N_mem = we_n_r;
    assign sram_OE_N_mem = oe_n_r;
    assign sram_CE_N_mem = ce_n_r;
endmodule

// File: tb/tb_el_pipeline_cpu.sv
// Bench for el_pipeline_cpu: async SRAM model, ISA-level reference of the ROM program, bus write scoreboard.
module tb_el_pipeline_cpu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fwd = 1'b1;
    wire  [15:0] dq;
    logic [17:0] addr;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;

    always #5 clk = ~clk;

    el_pipeline_cpu dut (
        .CLOCK_50(clk), .reset(rst), .forward_enable(fwd), .sram_DQ_mem(dq),
        .sram_ADDR_mem(addr), .sram_UB_N_mem(ub_n), .sram_LB_N_mem(lb_n),
        .sram_WE_N_mem(we_n), .sram_CE_N_mem(ce_n), .sram_OE_N_mem(oe_n)
    );

    logic [15:0] sram_mem [0:1023];
    assign dq = (!oe_n && we_n) ? sram_mem[addr[9:0]] : 16'hzzzz;
    always @(posedge clk) if (!rst && !we_n) sram_mem[addr[9:0]] <= dq;

    typedef struct { int a; int d; } wr_t;
    wr_t golden[$];
    wr_t exp_q[$];
    logic [15:0] prog [0:63];
    int vectors = 0, miscompares = 0, cyc = 0, done_cyc = 0, base = 0;
    bit idle_chk = 1'b0;

    function automatic logic [15:0] enc(int op, int ra, int rb, int low6);
        return 16'((op << 12) | (ra << 9) | (rb << 6) | (low6 & 63));
    endfunction

    // Instruction-level execution of the program: every store becomes one expected bus write.
    task automatic build_golden();
        int r[8];
        int m[int];
        int pc, steps, op, ra, rb, rc, imm, a, nxt;
        bit halted;
        logic [15:0] w;
        golden = {};
`ifdef EL_SRAM_CLEAR_EN
        for (int i = 0; i < 64; i++) golden.push_back('{i, 0});
`endif
        for (int i = 0; i < 8; i++) r[i] = 0;
        pc = 0; steps = 0; halted = 1'b0;
        while (!halted && steps < 1000) begin
            w = prog[pc];
            op = int'(w[15:12]); ra = int'(w[11:9]); rb = int'(w[8:6]); rc = int'(w[5:3]);
            imm = int'($signed(w[5:0]));
            nxt = (pc + 1) % 64;
            a = (r[rb] + imm) & 16'hFFFF;
            case (op)
                1: r[ra] = (r[rb] + r[rc]) & 16'hFFFF;
                2: r[ra] = (r[rb] - r[rc]) & 16'hFFFF;
                3: r[ra] = r[rb] & r[rc];
                4: r[ra] = r[rb] | r[rc];
                5: r[ra] = a;
                6: r[ra] = m.exists(a) ? m[a] : 0;
                7: begin m[a] = r[ra]; golden.push_back('{a, r[ra]}); end
                8: if (r[ra] == r[rb]) nxt = (((pc + 1 + imm) % 64) + 64) % 64;
                15: halted = 1'b1;
                default: ;
            endcase
            r[0] = 0;
            pc = nxt;
            steps++;
        end
    endtask

    // Per-cycle bus checker: reset state, control sanity, idle DQ, and the ordered write scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            vectors++;
            if (ce_n !== 1'b1 || we_n !== 1'b1 || oe_n !== 1'b1 || dq !== 16'hzzzz) begin
                miscompares++;
                $display("FAIL reset_bus: got CE_N=%b WE_N=%b OE_N=%b DQ=%h, required 1 1 1 zzzz", ce_n, we_n, oe_n, dq);
            end
            exp_q = golden;
            cyc = 0;
        end else begin
            cyc++;
            if (cyc >= 2) begin
                vectors++;
                if (ce_n !== 1'b0 || ub_n !== 1'b0 || lb_n !== 1'b0 || (we_n === 1'b0 && oe_n === 1'b0)) begin
                    miscompares++;
                    $display("FAIL bus_ctrl: got CE_N=%b UB_N=%b LB_N=%b WE_N=%b OE_N=%b, required CE_N/UB_N/LB_N=0 and not both strobes", ce_n, ub_n, lb_n, we_n, oe_n);
                end
            end
            if (idle_chk) begin
                vectors++;
                if (we_n !== 1'b1 || oe_n !== 1'b1) begin
                    miscompares++;
                    $display("FAIL halt_idle: got WE_N=%b OE_N=%b, required 1 1", we_n, oe_n);
                end
            end
            if (we_n === 1'b0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: got M[%0d]=%0d, required no write", addr, dq);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (addr !== 18'(e.a) || dq !== 16'(e.d)) begin
                        miscompares++;
                        $display("FAIL write_seq: got M[%0d]=%0d, required M[%0d]=%0d", addr, dq, e.a, e.d);
                    end
                    if (exp_q.size() == 0) done_cyc = cyc;
                end
            end else if (oe_n === 1'b1) begin
                vectors++;
                if (dq !== 16'hzzzz) begin
                    miscompares++;
                    $display("FAIL dq_idle: got DQ=%h, required zzzz", dq);
                end
            end
        end
    end

    task automatic do_reset(int n);
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_done(int budget, string name);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_timeout: got %0d writes outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic idle_window(int n);
        repeat (3) @(posedge clk);
        #2; idle_chk = 1'b1;
        repeat (n) @(posedge clk);
        #2; idle_chk = 1'b0;
    endtask

    initial begin
        int t_fwd, t_stall, rst_at, k;
        bit fired, found9;
        for (int i = 0; i < 1024; i++) sram_mem[i] = 16'h0000;
        for (int i = 0; i < 64; i++) prog[i] = 16'h0000;
        prog[0]  = enc(5, 1, 0, 5);      // ADDI r1,r0,5
        prog[1]  = enc(5, 2, 1, 3);      // ADDI r2,r1,3
        prog[2]  = enc(1, 3, 1, 2 << 3); // ADD r3,r1,r2
        prog[3]  = enc(7, 3, 0, 2);      // SW r3,2(r0)
        prog[4]  = enc(6, 4, 0, 2);      // LW r4,2(r0)
        prog[5]  = enc(1, 5, 4, 4 << 3); // ADD r5,r4,r4
        prog[6]  = enc(7, 5, 0, 3);      // SW r5,3(r0)
        prog[7]  = enc(8, 0, 0, 1);      // BEQ r0,r0,+1
        prog[8]  = enc(7, 1, 0, 9);      // SW r1,9(r0)
        prog[9]  = enc(2, 6, 5, 3 << 3); // SUB r6,r5,r3
        prog[10] = enc(7, 6, 0, 4);      // SW r6,4(r0)
        prog[11] = enc(15, 0, 0, 0);     // HALT
        build_golden();
`ifdef EL_SRAM_CLEAR_EN
        base = 64;
`endif
        vectors++;
        if (golden.size() != base + 3) begin
            miscompares++;
            $display("FAIL model_len: got %0d writes, required %0d", golden.size(), base + 3);
        end else begin
            int ea[3] = '{2, 3, 4};
            int ed[3] = '{13, 26, 13};
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (golden[base + i].a != ea[i] || golden[base + i].d != ed[i]) begin
                    miscompares++;
                    $display("FAIL model_write%0d: got M[%0d]=%0d, required M[%0d]=%0d", i, golden[base + i].a, golden[base + i].d, ea[i], ed[i]);
                end
            end
        end
        found9 = 1'b0;
        foreach (golden[i]) if (golden[i].a == 9) found9 = 1'b1;
        vectors++;
        if (found9) begin
            miscompares++;
            $display("FAIL model_skip: got a write to addr 9, required none");
        end

        // Forwarding on, then interlock only; the latter must take strictly longer.
        fwd = 1'b1;
        do_reset(3);
        wait_done(400, "fwd_run");
        t_fwd = done_cyc;
        idle_window(55);
        fwd = 1'b0;
        do_reset(3);
        wait_done(400, "stall_run");
        t_stall = done_cyc;
        idle_window(55);
        vectors++;
        if (!(t_stall > t_fwd)) begin
            miscompares++;
            $display("FAIL stall_slower: got %0d cycles with interlock vs %0d with forwarding, required more", t_stall, t_fwd);
        end

        // Long reset, then reset again right after the M[2] write: the sequence must restart.
        fwd = 1'b1;
        do_reset(6);
        k = 0;
        while (exp_q.size() > golden.size() - base - 1 && k < 400) begin
            @(posedge clk); #2;
            k++;
        end
        vectors++;
        if (exp_q.size() > golden.size() - base - 1) begin
            miscompares++;
            $display("FAIL first_store_timeout: got %0d writes outstanding, required %0d", exp_q.size(), golden.size() - base - 1);
        end
        do_reset(2);
        wait_done(400, "restart_run");
        idle_window(10);

        // Random forward_enable toggling and a random mid-run reset.
        for (int run = 0; run < 8; run++) begin
            fwd = 1'($urandom_range(0, 1));
            rst_at = int'($urandom_range(4, 60 + base));
            do_reset(1 + int'($urandom_range(0, 2)));
            k = 0; fired = 1'b0;
            while (k < 800 && (exp_q.size() != 0 || !fired)) begin
                @(posedge clk); #2;
                k++;
                if ($urandom_range(0, 2) == 0) fwd = ~fwd;
                if (!fired && k == rst_at) begin
                    fired = 1'b1;
                    rst = 1'b1;
                    repeat (1 + int'($urandom_range(0, 1))) @(posedge clk);
                    #2;
                    rst = 1'b0;
                end
            end
            vectors++;
            if (exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL random_run%0d_timeout: got %0d writes outstanding, required 0", run, exp_q.size());
            end
            idle_window(5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
